// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing single-port DMEM between port A (CPU) and port B (debug).
// Define DMEM_ARB_BURST_EN to let a locked B keep up to MAX_BURST consecutive grants.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          SYS_clk,
    input  logic          SYS_reset,
    input  logic          A_req,
    input  logic          A_we,
    input  logic [AW-1:0] A_addr,
    input  logic [DW-1:0] A_wdata,
    output logic          A_ack,
    output logic [DW-1:0] A_rdata,
    output logic          A_stall,
    input  logic          B_req,
    input  logic          B_we,
    input  logic [AW-1:0] B_addr,
    input  logic [DW-1:0] B_wdata,
    output logic          B_ack,
    output logic [DW-1:0] B_rdata,
    input  logic          B_lock,
    output logic [AW-1:0] MEM_addr,
    output logic [DW-1:0] MEM_wdata,
    output logic          MEM_we,
    output logic          MEM_re,
    input  logic [DW-1:0] MEM_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state;
    logic          owner;
    logic          rr_last;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          a_ack_q;
    logic          b_ack_q;
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;
    logic          lock_win;
    logic          grant;
    logic          grant_b;
    logic          in_access;

    assign grant     = A_req | B_req;
    assign grant_b   = lock_win | (B_req & (~A_req | ~rr_last));
    assign in_access = state == ACCESS;

`ifdef DMEM_ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] lock_cnt;

    assign lock_win = rr_last & B_lock & B_req & (lock_cnt < CW'(MAX_BURST));

    // Saturates so an unopposed locked B cannot wrap the counter back under the limit.
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset)
            lock_cnt <= '0;
        else if (!B_lock)
            lock_cnt <= '0;
        else if (state == IDLE && grant)
            lock_cnt <= grant_b ? (lock_cnt == CW'(MAX_BURST) ? lock_cnt : lock_cnt + 1'b1) : '0;
    end
`else
    localparam int UNUSED_BURST = MAX_BURST;
    logic unused_lock;

    assign unused_lock = B_lock;
    assign lock_win    = 1'b0;
`endif

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            rr_last   <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state   <= state == IDLE ? (grant ? ACCESS : IDLE) : in_access ? DONE : IDLE;
            a_ack_q <= in_access & ~owner;
            b_ack_q <= in_access & owner;
            if (state == IDLE && grant) begin
                owner   <= grant_b;
                rr_last <= grant_b;
                we_q    <= grant_b ? B_we : A_we;
                addr_q  <= grant_b ? B_addr : A_addr;
                wdata_q <= grant_b ? B_wdata : A_wdata;
            end
            if (in_access && !we_q && !owner)
                a_rdata_q <= MEM_rdata;
            if (in_access && !we_q && owner)
                b_rdata_q <= MEM_rdata;
        end
    end

    // Strobes derive from state so an asynchronous reset drops them at once.
    assign MEM_we    = in_access & we_q;
    assign MEM_re    = in_access & ~we_q;
    assign MEM_addr  = addr_q;
    assign MEM_wdata = wdata_q;
    assign A_ack     = a_ack_q;
    assign B_ack     = b_ack_q;
    assign A_rdata   = a_rdata_q;
    assign B_rdata   = b_rdata_q;
    assign A_stall   = A_req & ~a_ack_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a small DMEM model.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          SYS_clk = 1'b0;
    logic          SYS_reset = 1'b0;
    logic          A_req = 1'b0, A_we = 1'b0;
    logic [AW-1:0] A_addr = '0;
    logic [DW-1:0] A_wdata = '0;
    logic          A_ack, A_stall;
    logic [DW-1:0] A_rdata;
    logic          B_req = 1'b0, B_we = 1'b0, B_lock = 1'b0;
    logic [AW-1:0] B_addr = '0;
    logic [DW-1:0] B_wdata = '0;
    logic          B_ack;
    logic [DW-1:0] B_rdata;
    logic [AW-1:0] MEM_addr;
    logic [DW-1:0] MEM_wdata;
    logic          MEM_we, MEM_re;
    logic [DW-1:0] MEM_rdata;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 SYS_clk = ~SYS_clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
        .A_req(A_req), .A_we(A_we), .A_addr(A_addr), .A_wdata(A_wdata),
        .A_ack(A_ack), .A_rdata(A_rdata), .A_stall(A_stall),
        .B_req(B_req), .B_we(B_we), .B_addr(B_addr), .B_wdata(B_wdata),
        .B_ack(B_ack), .B_rdata(B_rdata), .B_lock(B_lock),
        .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata), .MEM_we(MEM_we), .MEM_re(MEM_re),
        .MEM_rdata(MEM_rdata)
    );

    logic [DW-1:0] dmem [0:255];
    assign MEM_rdata = dmem[MEM_addr[7:0]];
    always @(posedge SYS_clk) if (MEM_we) dmem[MEM_addr[7:0]] <= MEM_wdata;

    task automatic tick();
        @(posedge SYS_clk);
        #1;
    endtask

    task automatic idle_inputs();
        A_req = 0; A_we = 0; A_addr = '0; A_wdata = '0;
        B_req = 0; B_we = 0; B_addr = '0; B_wdata = '0; B_lock = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        SYS_reset = 0;
        tick();
        tick();
        SYS_reset = 1;
        tick();
    endtask

    task automatic test_reset();
        SYS_reset = 0;
        for (int i = 0; i < 3; i++) begin
            A_req = 1'($urandom); A_we = 1'($urandom); A_addr = $urandom; A_wdata = $urandom;
            B_req = 1'($urandom); B_we = 1'($urandom); B_addr = $urandom; B_wdata = $urandom;
            B_lock = 1'($urandom);
            tick();
            n_cmp++; if (A_ack !== 1'b0 || B_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got A=%b B=%b want 0", A_ack, B_ack); end
            n_cmp++; if (A_rdata !== '0 || B_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got A=%h B=%h want 0", A_rdata, B_rdata); end
            n_cmp++; if (MEM_we !== 1'b0 || MEM_re !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got we=%b re=%b want 0", MEM_we, MEM_re); end
            n_cmp++; if (MEM_addr !== '0 || MEM_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0", MEM_addr, MEM_wdata); end
            n_cmp++; if (A_stall !== A_req) begin n_fail++; $display("FAIL reset_stall got %b want %b", A_stall, A_req); end
        end
        idle_inputs();
        SYS_reset = 1;
        tick();
        tick();
        n_cmp++; if (MEM_we !== 1'b0 || MEM_re !== 1'b0 || A_ack !== 1'b0 || B_ack !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got we=%b re=%b aack=%b back=%b want 0", MEM_we, MEM_re, A_ack, B_ack); end
    endtask

    task automatic test_a_write_read();
        A_req = 1; A_we = 1; A_addr = 32'h10; A_wdata = 32'hDEADBEEF;
        tick();
        n_cmp++; if (MEM_we !== 1'b1 || MEM_re !== 1'b0) begin n_fail++; $display("FAIL a_wr_strobe got we=%b re=%b want 1/0", MEM_we, MEM_re); end
        n_cmp++; if (MEM_addr !== 32'h10 || MEM_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL a_wr_bus got %h/%h want 10/deadbeef", MEM_addr, MEM_wdata); end
        n_cmp++; if (A_ack !== 1'b0) begin n_fail++; $display("FAIL a_wr_early_ack got %b want 0", A_ack); end
        tick();
        n_cmp++; if (A_ack !== 1'b1 || MEM_we !== 1'b0) begin n_fail++; $display("FAIL a_wr_ack got ack=%b we=%b want 1/0", A_ack, MEM_we); end
        A_req = 0;
        tick();
        n_cmp++; if (dmem[8'h10] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL a_wr_mem got %h want deadbeef", dmem[8'h10]); end
        A_req = 1; A_we = 0; A_wdata = 32'h0;
        tick();
        n_cmp++; if (MEM_re !== 1'b1 || MEM_we !== 1'b0 || MEM_addr !== 32'h10) begin n_fail++; $display("FAIL a_rd_strobe got re=%b we=%b addr=%h want 1/0/10", MEM_re, MEM_we, MEM_addr); end
        tick();
        n_cmp++; if (A_ack !== 1'b1 || A_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL a_rd_data got ack=%b data=%h want 1/deadbeef", A_ack, A_rdata); end
        A_req = 0;
        tick();
        n_cmp++; if (A_ack !== 1'b0 || A_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL a_rd_hold got ack=%b data=%h want 0/deadbeef", A_ack, A_rdata); end
    endtask

    // Last owner is A, so B wins the tie and A stalls through B's access and its own.
    task automatic test_stall();
        A_req = 1; A_we = 0; A_addr = 32'h10;
        B_req = 1; B_we = 1; B_addr = 32'h50; B_wdata = 32'h1234;
        for (int t = 0; t < 6; t++) begin
            if (t > 0) tick(); else #1;
            n_cmp++; if (A_stall !== (t < 5)) begin n_fail++; $display("FAIL stall_t%0d got %b want %b", t, A_stall, t < 5); end
            n_cmp++; if (A_ack !== (t == 5) || B_ack !== (t == 2)) begin n_fail++; $display("FAIL stall_ack_t%0d got A=%b B=%b want %b/%b", t, A_ack, B_ack, t == 5, t == 2); end
            if (t == 2) B_req = 0;
        end
        n_cmp++; if (A_rdata !== 32'hDEADBEEF || dmem[8'h50] !== 32'h1234) begin n_fail++; $display("FAIL stall_data got rdata=%h mem=%h want deadbeef/1234", A_rdata, dmem[8'h50]); end
        A_req = 0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        A_req = 1; A_we = 1; A_addr = 32'h30; A_wdata = 32'h11;
        B_req = 1; B_we = 1; B_addr = 32'h40; B_wdata = 32'h22;
        for (int t = 0; t < 12; t++) begin
            if (t > 0) tick(); else #1;
            n_cmp++; if (A_ack !== (t == 2 || t == 8) || B_ack !== (t == 5 || t == 11)) begin n_fail++; $display("FAIL rr_ack_t%0d got A=%b B=%b want %b/%b", t, A_ack, B_ack, t == 2 || t == 8, t == 5 || t == 11); end
            if (t % 3 == 1) begin
                n_cmp++; if (MEM_we !== 1'b1 || MEM_addr !== ((t % 6 == 1) ? 32'h30 : 32'h40)) begin n_fail++; $display("FAIL rr_grant_t%0d got we=%b addr=%h want 1/%h", t, MEM_we, MEM_addr, (t % 6 == 1) ? 32'h30 : 32'h40); end
            end
        end
        idle_inputs();
        tick();
        n_cmp++; if (dmem[8'h30] !== 32'h11 || dmem[8'h40] !== 32'h22) begin n_fail++; $display("FAIL rr_mem got %h/%h want 11/22", dmem[8'h30], dmem[8'h40]); end
    endtask

    task automatic test_reset_mid_access();
        B_req = 1; B_we = 1; B_addr = 32'h20; B_wdata = 32'h77;
        tick();
        tick();
        n_cmp++; if (B_ack !== 1'b1) begin n_fail++; $display("FAIL mid_preload_ack got %b want 1", B_ack); end
        B_req = 0;
        tick();
        B_req = 1; B_wdata = 32'h5;
        tick();
        n_cmp++; if (MEM_we !== 1'b1 || MEM_wdata !== 32'h5) begin n_fail++; $display("FAIL mid_access_we got we=%b data=%h want 1/5", MEM_we, MEM_wdata); end
        #2 SYS_reset = 0;
        #1;
        n_cmp++; if (MEM_we !== 1'b0 || MEM_re !== 1'b0) begin n_fail++; $display("FAIL mid_strobe_drop got we=%b re=%b want 0", MEM_we, MEM_re); end
        B_req = 0;
        tick();
        n_cmp++; if (B_ack !== 1'b0 || dmem[8'h20] !== 32'h77) begin n_fail++; $display("FAIL mid_no_write got ack=%b mem=%h want 0/77", B_ack, dmem[8'h20]); end
        SYS_reset = 1;
        tick();
        tick();
        n_cmp++; if (B_ack !== 1'b0 || MEM_we !== 1'b0 || dmem[8'h20] !== 32'h77) begin n_fail++; $display("FAIL mid_after got ack=%b we=%b mem=%h want 0/0/77", B_ack, MEM_we, dmem[8'h20]); end
    endtask

`ifdef DMEM_ARB_BURST_EN
    task automatic test_burst();
        int nb = 0;
        bit seen_a = 0;
        bit overlap = 0;
        do_reset();
        A_req = 1; A_we = 0; A_addr = 32'h30;
        B_req = 1; B_we = 0; B_addr = 32'h40; B_lock = 1;
        for (int t = 0; t < 40 && !seen_a; t++) begin
            tick();
            if (A_ack && B_ack) overlap = 1;
            if (B_ack) nb++;
            if (A_ack) seen_a = 1;
        end
        n_cmp++; if (!seen_a) begin n_fail++; $display("FAIL burst_a_timeout got no A_ack want A_ack within 40 cycles"); end
        n_cmp++; if (nb !== 4) begin n_fail++; $display("FAIL burst_b_count got %0d want 4", nb); end
        n_cmp++; if (overlap) begin n_fail++; $display("FAIL burst_overlap got both acks want exclusive"); end
        idle_inputs();
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_a_write_read();
        test_stall();
        test_round_robin();
        test_reset_mid_access();
`ifdef DMEM_ARB_BURST_EN
        test_burst();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
